// File: rtl/collision_event_latch_if.sv
// Event handshake bundle from the collision latch to the ball controller.
// The master drives the event and the slave acknowledges it.
interface collision_event_latch_if;
  logic        evtValid;
  logic        evtAck;
  logic [6:0]  evtFlags;
  logic [2:0]  evtCode;
  logic        overrun;
  logic [10:0] hitX;
  logic [10:0] hitY;
  logic [10:0] hitTileX;
  logic [10:0] hitTileY;

  modport master (
    output evtValid,
    output evtFlags,
    output evtCode,
    output overrun,
    output hitX,
    output hitY,
    output hitTileX,
    output hitTileY,
    input  evtAck
  );

  modport slave (
    input  evtValid,
    input  evtFlags,
    input  evtCode,
    input  overrun,
    input  hitX,
    input  hitY,
    input  hitTileX,
    input  hitTileY,
    output evtAck
  );
endinterface

// File: rtl/collision_event_latch.sv
// Per-frame ball collision collector; reports one prioritised event per frame.
// HIT_POINT_EN adds capture of the first overlap pixel and its tile origin.
module collision_event_latch #(
  parameter int TELEPORT_COOLDOWN = 16,
  parameter int COOLDOWN_W        = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        ballDR,
  input  logic        boardersDrawReq,
  input  logic        diagonalBoarderDrawReq,
  input  logic        oneSidedBorderDR,
  input  logic        BlockDR,
  input  logic        lossDR,
  input  logic        teleportDR,
  input  logic        speedVarDR,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] topleftX,
  input  logic [10:0] topleftY,
  collision_event_latch_if.master evt
);

  typedef enum logic {
    COLLECT,
    REPORT
  } state_t;

  state_t state;
  state_t stateNxt;

  logic [6:0] acc;
  logic [6:0] accNxt;
  logic [6:0] hitVec;
  logic [6:0] snap;
  logic [6:0] flagsQ;
  logic [6:0] flagsNxt;
  logic [2:0] codeQ;
  logic [2:0] codeNxt;
  logic       ovrQ;
  logic       ovrNxt;
  logic       takeSnap;
  logic       coolIdle;

  logic [COOLDOWN_W-1:0] cooldown;
  logic [COOLDOWN_W-1:0] cooldownNxt;

  function automatic logic [2:0] prioCode(
    input logic [6:0] f
  );
    logic [2:0] c;
    c = 3'd0;
    priority case (1'b1)
      f[4]:    c = 3'd7;
      f[5]:    c = 3'd6;
      f[1]:    c = 3'd5;
      f[2]:    c = 3'd4;
      f[0]:    c = 3'd3;
      f[6]:    c = 3'd2;
      f[3]:    c = 3'd1;
      default: c = 3'd0;
    endcase
    return c;
  endfunction

  assign coolIdle = (cooldown == '0);

  // Teleport overlaps are invisible while the cooldown runs.
  assign hitVec = {7{ballDR}} & {
    speedVarDR,
    teleportDR & coolIdle,
    lossDR,
    BlockDR,
    oneSidedBorderDR,
    diagonalBoarderDrawReq,
    boardersDrawReq
  };

  assign snap = acc | hitVec;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= COLLECT;
      acc      <= '0;
      flagsQ   <= '0;
      codeQ    <= '0;
      ovrQ     <= 1'b0;
      cooldown <= '0;
    end else begin
      state    <= stateNxt;
      acc      <= accNxt;
      flagsQ   <= flagsNxt;
      codeQ    <= codeNxt;
      ovrQ     <= ovrNxt;
      cooldown <= cooldownNxt;
    end
  end

  always_comb begin
    stateNxt    = state;
    accNxt      = snap;
    flagsNxt    = flagsQ;
    codeNxt     = codeQ;
    ovrNxt      = ovrQ;
    cooldownNxt = cooldown;
    takeSnap    = 1'b0;
    if (startOfFrame) begin
      accNxt   = '0;
      takeSnap = (state == COLLECT) || evt.evtAck;
      if (takeSnap) begin
        ovrNxt = 1'b0;
        if (snap != '0) begin
          flagsNxt = snap;
          codeNxt  = prioCode(snap);
          stateNxt = REPORT;
        end else begin
          stateNxt = COLLECT;
        end
      end else if (snap != '0) begin
        ovrNxt = 1'b1;
      end
      if (takeSnap && snap[5]) begin
        cooldownNxt = COOLDOWN_W'(TELEPORT_COOLDOWN);
      end else if (!coolIdle) begin
        cooldownNxt = cooldown - 1'b1;
      end
    end else if (state == REPORT && evt.evtAck) begin
      stateNxt = COLLECT;
      ovrNxt   = 1'b0;
    end
  end

  assign evt.evtValid = (state == REPORT);
  assign evt.evtFlags = flagsQ;
  assign evt.evtCode  = codeQ;
  assign evt.overrun  = ovrQ;

`ifdef HIT_POINT_EN
  logic [10:0] pxD;
  logic [10:0] pyD;
  logic [10:0] txD;
  logic [10:0] tyD;
  logic [10:0] shX;
  logic [10:0] shY;
  logic [10:0] shTX;
  logic [10:0] shTY;
  logic        shValid;
  logic [10:0] hXQ;
  logic [10:0] hYQ;
  logic [10:0] hTXQ;
  logic [10:0] hTYQ;
  logic        anyHit;

  assign anyHit = |hitVec;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pxD     <= '0;
      pyD     <= '0;
      txD     <= '0;
      tyD     <= '0;
      shX     <= '0;
      shY     <= '0;
      shTX    <= '0;
      shTY    <= '0;
      shValid <= 1'b0;
      hXQ     <= '0;
      hYQ     <= '0;
      hTXQ    <= '0;
      hTYQ    <= '0;
    end else begin
      pxD <= pixelX;
      pyD <= pixelY;
      txD <= topleftX;
      tyD <= topleftY;
      if (startOfFrame) begin
        shX     <= '0;
        shY     <= '0;
        shTX    <= '0;
        shTY    <= '0;
        shValid <= 1'b0;
      end else if (anyHit && !shValid) begin
        shX     <= pxD;
        shY     <= pyD;
        shTX    <= txD;
        shTY    <= tyD;
        shValid <= 1'b1;
      end
      // A first overlap on the frame-start cycle itself is used directly.
      if (takeSnap && snap != '0) begin
        hXQ  <= shValid ? shX  : pxD;
        hYQ  <= shValid ? shY  : pyD;
        hTXQ <= shValid ? shTX : txD;
        hTYQ <= shValid ? shTY : tyD;
      end
    end
  end

  assign evt.hitX     = hXQ;
  assign evt.hitY     = hYQ;
  assign evt.hitTileX = hTXQ;
  assign evt.hitTileY = hTYQ;
`else
  logic unusedCoords;

  assign unusedCoords = ^{pixelX, pixelY, topleftX, topleftY};

  assign evt.hitX     = '0;
  assign evt.hitY     = '0;
  assign evt.hitTileX = '0;
  assign evt.hitTileY = '0;
`endif

endmodule

// File: tb/tb_collision_event_latch.sv
// Directed bench for collision_event_latch.
// Cooldown shortened to 2 frames to reach the re-arm case quickly.
module tb_collision_event_latch;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        ballDR;
  logic [6:0]  req;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic [10:0] topleftX;
  logic [10:0] topleftY;

  int checks = 0;
  int errors = 0;

  collision_event_latch_if evt();

  collision_event_latch #(
    .TELEPORT_COOLDOWN(2),
    .COOLDOWN_W(8)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .ballDR(ballDR),
    .boardersDrawReq(req[0]),
    .diagonalBoarderDrawReq(req[1]),
    .oneSidedBorderDR(req[2]),
    .BlockDR(req[3]),
    .lossDR(req[4]),
    .teleportDR(req[5]),
    .speedVarDR(req[6]),
    .pixelX(pixelX),
    .pixelY(pixelY),
    .topleftX(topleftX),
    .topleftY(topleftY),
    .evt(evt)
  );

  always #5 clk = ~clk;

  task automatic checkEq(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setPix(
    input logic [10:0] x,
    input logic [10:0] y,
    input logic [10:0] tx,
    input logic [10:0] ty
  );
    pixelX   = x;
    pixelY   = y;
    topleftX = tx;
    topleftY = ty;
    tick();
  endtask

  task automatic overlap(
    input logic [6:0] r,
    input int         n
  );
    ballDR = 1'b1;
    req    = r;
    repeat (n) tick();
    ballDR = 1'b0;
    req    = '0;
  endtask

  task automatic sof(input logic ack);
    startOfFrame = 1'b1;
    evt.evtAck   = ack;
    tick();
    startOfFrame = 1'b0;
    evt.evtAck   = 1'b0;
  endtask

  task automatic ackEvt();
    evt.evtAck = 1'b1;
    tick();
    evt.evtAck = 1'b0;
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    ballDR       = 1'b0;
    req          = '0;
    pixelX       = '0;
    pixelY       = '0;
    topleftX     = '0;
    topleftY     = '0;
    evt.evtAck   = 1'b0;
    tick();
    tick();
    checkEq("rst_valid", {31'd0, evt.evtValid}, 32'd0);
    checkEq("rst_flags", {25'd0, evt.evtFlags}, 32'd0);
    checkEq("rst_code", {29'd0, evt.evtCode}, 32'd0);
    checkEq("rst_ovr", {31'd0, evt.overrun}, 32'd0);
    checkEq("rst_hitx", {21'd0, evt.hitX}, 32'd0);
    resetN = 1'b1;
    tick();

    // border overlap for 3 cycles at (200,10)
    setPix(11'd200, 11'd10, 11'd192, 11'd0);
    overlap(7'h01, 3);
    checkEq("pre_sof_valid", {31'd0, evt.evtValid}, 32'd0);
    sof(1'b0);
    checkEq("b_valid", {31'd0, evt.evtValid}, 32'd1);
    checkEq("b_flags", {25'd0, evt.evtFlags}, 32'h01);
    checkEq("b_code", {29'd0, evt.evtCode}, 32'd3);
`ifdef HIT_POINT_EN
    checkEq("b_hitx", {21'd0, evt.hitX}, 32'd200);
    checkEq("b_hity", {21'd0, evt.hitY}, 32'd10);
    checkEq("b_tilex", {21'd0, evt.hitTileX}, 32'd192);
    checkEq("b_tiley", {21'd0, evt.hitTileY}, 32'd0);
`else
    checkEq("b_hitx", {21'd0, evt.hitX}, 32'd0);
    checkEq("b_tiley", {21'd0, evt.hitTileY}, 32'd0);
`endif
    ackEvt();
    checkEq("b_ack_valid", {31'd0, evt.evtValid}, 32'd0);

    // ack with nothing pending has no effect
    ackEvt();
    checkEq("idle_ack", {31'd0, evt.evtValid}, 32'd0);

    // request without ball is not a collision
    ballDR = 1'b0;
    req    = 7'h7F;
    tick();
    req = '0;
    sof(1'b0);
    checkEq("noball_valid", {31'd0, evt.evtValid}, 32'd0);

    // loss + block in one frame
    setPix(11'd300, 11'd40, 11'd288, 11'd32);
    overlap(7'h18, 1);
    sof(1'b0);
    checkEq("lb_flags", {25'd0, evt.evtFlags}, 32'h18);
    checkEq("lb_code", {29'd0, evt.evtCode}, 32'd7);
`ifdef HIT_POINT_EN
    checkEq("lb_hitx", {21'd0, evt.hitX}, 32'd300);
    checkEq("lb_tiley", {21'd0, evt.hitTileY}, 32'd32);
`endif
    ackEvt();

    // overrun: pending event, next frame with speedVar, no ack
    overlap(7'h01, 1);
    sof(1'b0);
    sof(1'b0);
    checkEq("empty_no_ovr", {31'd0, evt.overrun}, 32'd0);
    overlap(7'h40, 2);
    sof(1'b0);
    checkEq("ovr_set", {31'd0, evt.overrun}, 32'd1);
    checkEq("ovr_flags", {25'd0, evt.evtFlags}, 32'h01);
    checkEq("ovr_code", {29'd0, evt.evtCode}, 32'd3);
    checkEq("ovr_valid", {31'd0, evt.evtValid}, 32'd1);
    ackEvt();
    checkEq("ovr_ack_valid", {31'd0, evt.evtValid}, 32'd0);
    checkEq("ovr_ack_clr", {31'd0, evt.overrun}, 32'd0);

    // ack coincident with frame start retires and re-snapshots
    overlap(7'h01, 1);
    sof(1'b0);
    overlap(7'h02, 1);
    sof(1'b1);
    checkEq("swap_valid", {31'd0, evt.evtValid}, 32'd1);
    checkEq("swap_flags", {25'd0, evt.evtFlags}, 32'h02);
    checkEq("swap_code", {29'd0, evt.evtCode}, 32'd5);
    // coincident ack with empty frame drops back to idle
    sof(1'b1);
    checkEq("swap_empty", {31'd0, evt.evtValid}, 32'd0);

    // teleport cooldown of 2 frames
    overlap(7'h20, 1);
    sof(1'b0);
    checkEq("tp_code", {29'd0, evt.evtCode}, 32'd6);
    checkEq("tp_flags", {25'd0, evt.evtFlags}, 32'h20);
    ackEvt();
    overlap(7'h20, 1);
    sof(1'b0);
    checkEq("tp_cool1", {31'd0, evt.evtValid}, 32'd0);
    overlap(7'h20, 1);
    sof(1'b0);
    checkEq("tp_cool2", {31'd0, evt.evtValid}, 32'd0);
    overlap(7'h20, 1);
    sof(1'b0);
    checkEq("tp_rearm_v", {31'd0, evt.evtValid}, 32'd1);
    checkEq("tp_rearm_c", {29'd0, evt.evtCode}, 32'd6);
    ackEvt();

    // asynchronous reset while an event is pending
    overlap(7'h04, 1);
    sof(1'b0);
    checkEq("pre_rst_code", {29'd0, evt.evtCode}, 32'd4);
    #2;
    resetN = 1'b0;
    #1;
    checkEq("arst_valid", {31'd0, evt.evtValid}, 32'd0);
    checkEq("arst_flags", {25'd0, evt.evtFlags}, 32'd0);
    checkEq("arst_code", {29'd0, evt.evtCode}, 32'd0);
    checkEq("arst_hitx", {21'd0, evt.hitX}, 32'd0);
    tick();
    resetN = 1'b1;
    tick();
    tick();
    sof(1'b0);
    checkEq("post_rst_empty", {31'd0, evt.evtValid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/collision_event_latch.md
# collision_event_latch

Per-frame collision collector for the pinball playfield. Samples the per-pixel draw requests produced by the background drawer against the ball's draw request, accumulates every obstacle class the ball overlapped during one video frame, and hands a single prioritised event to the ball controller at the next frame boundary over a valid/ack handshake. Sits between the VGA drawing layer and the game/ball physics logic.

## Interface
Parameters:
- TELEPORT_COOLDOWN, 16: frames during which teleport overlap is suppressed after a reported teleport (1..255).
- COOLDOWN_W, 8: width of cooldown counter.

Ports:
- clk  in  1  system/pixel clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse at frame start.
- ballDR  in  1  ball pixel is drawn at current pixel.
- boardersDrawReq, diagonalBoarderDrawReq, oneSidedBorderDR, BlockDR, lossDR, teleportDR, speedVarDR  in  1 each  background region requests (registered, one cycle behind pixelX/Y).
- pixelX, pixelY  in  11  current scan coordinate.
- topleftX, topleftY  in  11  32-px tile origin of current pixel (combinational from pixelX/Y).
- evtValid  out  1  event available.
- evtAck  in  1  consumer accepts event.
- evtFlags  out  7  {speedVar, teleport, loss, block, oneSided, diagonal, border}, bit 6..0.
- evtCode  out  3  highest-priority class.
- overrun  out  1  a non-empty frame was dropped while an event was pending.
- hitX, hitY, hitTileX, hitTileY  out  11 each  first overlap pixel and its tile origin.

## Operation
- pixelX/Y and topleftX/Y delayed one register stage internally to align with the draw requests; ballDR is treated as aligned with the draw requests.
- Accumulator acc[6:0]: each cycle, acc |= ballDR & request for each class. Teleport bit masked while cooldown ≠ 0.
- States: COLLECT, REPORT. Accumulation runs in both.
- On startOfFrame (acc value includes that cycle's overlaps):
  - COLLECT, acc≠0: evtFlags←acc, evtCode←priority(acc), evtValid←1, go REPORT.
  - COLLECT, acc=0: no event.
  - REPORT without evtAck in same cycle: if acc≠0, overrun←1 and frame discarded; held event unchanged.
  - REPORT with evtAck same cycle: old event retired, new acc snapshotted as in COLLECT (stays REPORT if acc≠0, else COLLECT, evtValid←0).
  - acc cleared to 0 in all cases.
- evtAck while evtValid (no startOfFrame): evtValid←0, overrun←0, go COLLECT. evtAck while !evtValid ignored.
- evtFlags/evtCode held stable while evtValid.
- Priority, evtCode: loss=7, teleport=6, diagonal=5, oneSided=4, border=3, speedVar=2, block=1, none=0.
- Cooldown: loaded with TELEPORT_COOLDOWN when a snapshot containing teleport is taken; decremented by 1 on every other startOfFrame while ≠0; saturates at 0.

## Timing
- Reset: state COLLECT, acc=0, evtValid=0, evtFlags=0, evtCode=0, overrun=0, cooldown=0, hit outputs 0.
- Overlap to acc: 1 cycle. startOfFrame to evtValid high: 1 cycle (registered).
- evtValid falls the cycle after accepted evtAck.
- Reset asserted mid-frame or mid-handshake discards everything immediately.

## Configuration
- HIT_POINT_EN defined: on the first cycle of a frame with any unmasked overlap, capture delayed pixelX/Y and topleftX/Y into a shadow; copied to hitX/hitY/hitTileX/hitTileY on snapshot, held while evtValid; shadow cleared at startOfFrame.
- Undefined: hit outputs constant 0, no capture registers.

## Test plan
- ballDR & boardersDrawReq for 3 cycles at (200,10), then startOfFrame -> next cycle evtValid=1, evtFlags=7'h01, evtCode=3; hit (200,10)/(192,0) with HIT_POINT_EN.
- Same frame ballDR with lossDR and BlockDR -> evtFlags=7'h18, evtCode=7.
- Event pending, next frame overlaps speedVar, no ack -> overrun=1, evtFlags unchanged; evtAck -> evtValid=0, overrun=0.
- evtAck and startOfFrame same cycle with acc=7'h02 -> evtValid stays 1, evtFlags=7'h02, evtCode=5.
- Teleport overlap reported, TELEPORT_COOLDOWN=2; teleport overlap in next 2 frames -> no event; third frame -> evtCode=6.
- resetN low while evtValid=1 -> all outputs 0 asynchronously; frame with no overlap -> evtValid stays 0.
